zports: RTL and testbench
=========================

// Module: zports
// PURPOSE
// - Register file behind the ZX-bus decoder.
// - Consumes its write port (ports_wrena/ports_wrstb_n/ports_addr/ports_wrdata) and returns ports_rddata.
// - Drives the ROM-window map, the w5300/sl811 port-select and the chip reset pulses.
// - Collects w5300/sl811 interrupts into a Z80 INT request.
// - Write strobe is asynchronous Z80 timing; it is resynchronised into the fclk domain here.
// PARAMETERS
// - RST_CYCLES  16'd200  fclk cycles a chip reset is held low (>=2us at 28MHz for w5300)
// - SYNC_LEN    2        synchroniser flops on ports_wrstb_n and interrupt inputs (>=2)
// PORTS
// - fclk           in   1  system clock
// - rst_n          in   1  async active-low reset
// - ports_wrena    in   1  write targets this block (address decoded, za[15]=1)
// - ports_wrstb_n  in   1  async write strobe, low while Z80 IORQ&WR active
// - ports_addr     in   2  register index
// - ports_wrdata   in   8  write data, stable while strobe low
// - ports_rddata   out  8  read data for ports_addr (combinational mux)
// - rommap_win     out  2  16K window in which w5300 is memory-mapped
// - rommap_ena     out  1  memory mapping enable
// - w5300_ports    out  1  1: IO port routes to w5300, 0: to sl811
// - w5300_rst_n    out  1  w5300 reset, active low
// - sl811_rst_n    out  1  sl811 reset, active low
// - w5300_int_n    in   1  async, active low
// - sl811_intrq    in   1  async, active high
// - int_n          out  1  interrupt request to Z80, active low
// BEHAVIOUR
// - Register map:
//   - addr0: unused, reads 8'hFF, writes ignored.
//   - addr1 CTRL: [1:0] rommap_win, [2] rommap_ena, [3] w5300_ports, [7] int_ena.
//     Write 1 to [4] starts an sl811 reset; write 1 to [5] starts a w5300 reset; 0 has no effect.
//     Read: [4]/[5] = reset busy, [6] = 0.
//   - addr2 MASK: [1:0] enables for w5300 (bit0) and sl811 (bit1); [7:2] read 0.
//   - addr3 STAT: [1:0] sticky pending, write-1-to-clear. Read [5:4] = live synchronised raw levels, others 0.
// - Reset values:
//   - All registers 0; int_n=1; rommap_ena=0; w5300_ports=0.
//   - Both reset counters loaded with RST_CYCLES, so both chips are held in reset for RST_CYCLES fclk cycles after rst_n releases.
// - Write capture:
//   - ports_wrstb_n passes through a SYNC_LEN synchroniser; a further flop gives the edge detect.
//   - While the synchronised strobe is low, addr, data and wrena are sampled every cycle.
//   - Commit happens on the synchronised rising edge, using the last sample, and only if the sampled wrena=1.
//   - Registers are visible at most SYNC_LEN+2 fclk cycles after the strobe rises.
//   - Minimum strobe low width: SYNC_LEN+1 fclk cycles. Shorter pulses may be lost; they never corrupt state.
//   - Exactly one commit per strobe low period.
// - Reset pulses:
//   - Each chip has its own down-counter, 16 bits wide.
//   - Start while idle: load RST_CYCLES, assert rst low from the next cycle for exactly RST_CYCLES cycles.
//   - Start while busy: reload, which extends the pulse.
//   - rst outputs are registered.
// - Interrupts:
//   - Inputs pass through a SYNC_LEN synchroniser.
//   - STAT bit sets on the synchronised active level, i.e. level-sticky.
//   - Setting takes priority over a simultaneous W1C.
//   - int_n = ~(int_ena & |(STAT & MASK)), registered, one cycle after STAT updates.
//   - While a chip's reset is busy, its STAT bit is held 0.
// - Reads:
//   - ports_rddata is a combinational mux of ports_addr.
//   - Reads have no side effects (no read-to-clear).
// - Async reset mid-write: state returns to reset values; a strobe still low after reset releases commits normally on its rising edge.
// STRUCTURE
// - Shared package/include: register indices (REG_CTRL=2'd1, REG_MASK=2'd2, REG_STAT=2'd3), CTRL/STAT bit positions, RST_CYCLES default.
// - One sub-module, zports_rstgen: counter plus registered rst_n output, instantiated once per chip.
// - Synchronisers are inline flop chains.
// TESTING
// 1. Release rst_n -> both rst_n outputs low for exactly 200 fclk cycles, then high; ports_rddata @addr1 reads 8'h00 after release and 8'h30 during the hold.
// 2. Strobe low 6 cycles, addr1, data 8'h8E, wrena=1 -> within 4 cycles of the rising edge: rommap_win=2, rommap_ena=1, w5300_ports=1; addr1 reads 8'h8E. Same write with wrena=0 -> no change.
// 3. Write addr1 = 8'h20 -> w5300_rst_n low for 200 cycles; re-write at cycle 100 -> low until cycle 300; sl811_rst_n stays high.
// 4. MASK=8'h03, CTRL int_ena=1, w5300_int_n low 10 cycles -> STAT reads 8'h01, int_n=0 and stays 0 after the input returns high; W1C 8'h01 -> int_n=1.
// 5. sl811_intrq held high during a W1C of bit1 -> STAT bit1 stays 1 (set wins); int_ena=0 -> int_n=1 regardless of STAT.
// 6. rst_n pulsed low while strobe low with data 8'h04 -> registers stay 0 during reset; commit on the subsequent strobe rise sets rommap_ena=1.

Source files
------------

// File: rtl/zports_pkg.sv
// zports_pkg: shared definitions for the ZX-bus port register file.
// - Register indices and bit positions of the CTRL/STAT registers.
// - Default reset pulse length and synchroniser depth.
// - CTRL register storage type and the STAT next-state helper.
package zports_pkg;

  // Register indices on ports_addr
  localparam logic [1:0] REG_UNUSED = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_MASK   = 2'd2;
  localparam logic [1:0] REG_STAT   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_WIN_LSB = 0;
  localparam int CTRL_WIN_MSB = 1;
  localparam int CTRL_ROMENA  = 2;
  localparam int CTRL_W5PORTS = 3;
  localparam int CTRL_SLRST   = 4;
  localparam int CTRL_W5RST   = 5;
  localparam int CTRL_INTENA  = 7;

  // STAT / MASK bit positions
  localparam int STAT_W5    = 0;
  localparam int STAT_SL    = 1;
  localparam int STAT_W5RAW = 4;
  localparam int STAT_SLRAW = 5;

  // Defaults
  localparam logic [15:0] RST_CYCLES_DEF = 16'd200;
  localparam int          SYNC_LEN_DEF   = 2;

  // Stored CTRL bits (the reset-start bits are pulses, not storage)
  typedef struct packed {
    logic       int_ena;
    logic       w5300_ports;
    logic       rommap_ena;
    logic [1:0] rommap_win;
  } ctrl_t;

  // Next value of one sticky STAT bit: a busy chip forces 0, an active
  // interrupt level sets, and setting wins over a simultaneous W1C.
  function automatic logic stat_bit_next(input logic cur,
                                         input logic busy,
                                         input logic active,
                                         input logic clear);
    logic nxt;
    if (busy) begin
      nxt = 1'b0;
    end else if (active) begin
      nxt = 1'b1;
    end else if (clear) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/zports_rstgen.sv
// zports_rstgen: reset pulse generator for one peripheral chip.
// - start   : one-cycle request; (re)loads the counter, so a request while
//             busy extends the pulse.
// - chip_rst_n : registered active-low reset, low for exactly RST_CYCLES
//             cycles after the cycle carrying start.
// - busy    : high while chip_rst_n is low.
// After rst_n releases the counter is already loaded, so the chip is held in
// reset for RST_CYCLES cycles.
module zports_rstgen
  import zports_pkg::*;
#(
  parameter logic [15:0] RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic start,
  output logic chip_rst_n,
  output logic busy
);

  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic        chip_rst_n_r;

  // Counter next state: reload on start, otherwise count down to zero
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (start) begin
      cnt_nxt_s = RST_CYCLES;
    end else if (cnt_r != 16'd0) begin
      cnt_nxt_s = cnt_r - 16'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and output register; output derived from the next count so the
  // pulse starts in the cycle after start
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= RST_CYCLES;
      chip_rst_n_r <= (RST_CYCLES == 16'd0);
    end else begin
      cnt_r        <= cnt_nxt_s;
      chip_rst_n_r <= (cnt_nxt_s == 16'd0);
    end
  end

  assign chip_rst_n = chip_rst_n_r;
  assign busy       = ~chip_rst_n_r;

endmodule

// File: rtl/zports.sv
// zports: register file behind the ZX-bus decoder.
// Ports:
// - fclk, rst_n          : system clock, async active-low reset
// - ports_wrena          : write is addressed to this block
// - ports_wrstb_n        : async Z80 write strobe (low while IORQ&WR)
// - ports_addr/wrdata    : register index / write data
// - ports_rddata         : combinational read mux of ports_addr
// - rommap_win/ena       : w5300 memory-mapped window and enable
// - w5300_ports          : IO port select (1 = w5300, 0 = sl811)
// - w5300_rst_n/sl811_rst_n : chip reset pulses
// - w5300_int_n/sl811_intrq : async chip interrupts
// - int_n                : Z80 interrupt request
// Writes are captured in the fclk domain: the strobe is synchronised, the
// bus is sampled while the synchronised strobe is low, and the last sample
// commits on the synchronised rising edge.
module zports
  import zports_pkg::*;
#(
  parameter logic [15:0] RST_CYCLES = RST_CYCLES_DEF,
  parameter int          SYNC_LEN   = SYNC_LEN_DEF
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       ports_wrena,
  input  logic       ports_wrstb_n,
  input  logic [1:0] ports_addr,
  input  logic [7:0] ports_wrdata,
  output logic [7:0] ports_rddata,
  output logic [1:0] rommap_win,
  output logic       rommap_ena,
  output logic       w5300_ports,
  output logic       w5300_rst_n,
  output logic       sl811_rst_n,
  input  logic       w5300_int_n,
  input  logic       sl811_intrq,
  output logic       int_n
);

  logic [SYNC_LEN-1:0] wrstb_sync_r;
  logic                strobe_s;
  logic                strobe_d_r;
  logic [1:0]          smp_addr_r;
  logic [7:0]          smp_data_r;
  logic                smp_wrena_r;
  logic                commit_s;
  logic                wr_ctrl_s;
  logic                wr_mask_s;
  logic                wr_stat_s;

  logic [SYNC_LEN-1:0] w5_sync_r;
  logic [SYNC_LEN-1:0] sl_sync_r;
  logic                w5_lvl_s;
  logic                sl_lvl_s;

  ctrl_t               ctrl_r;
  logic [1:0]          mask_r;
  logic [1:0]          stat_r;
  logic [1:0]          stat_nxt_s;
  logic [1:0]          stat_w1c_s;
  logic                int_n_r;

  logic                w5_busy_s;
  logic                sl_busy_s;
  logic                w5_start_s;
  logic                sl_start_s;
  logic                unused_s;

  // Strobe synchroniser plus edge-detect flop; idle level is high
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wrstb_sync_r <= {SYNC_LEN{1'b1}};
      strobe_d_r   <= 1'b1;
    end else begin
      wrstb_sync_r <= {wrstb_sync_r[SYNC_LEN-2:0], ports_wrstb_n};
      strobe_d_r   <= strobe_s;
    end
  end

  assign strobe_s = wrstb_sync_r[SYNC_LEN-1];

  // Bus sampling while the synchronised strobe is low; the last sample is
  // what commits, so the bus only has to be stable during the low phase
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      smp_addr_r  <= 2'd0;
      smp_data_r  <= 8'd0;
      smp_wrena_r <= 1'b0;
    end else if (!strobe_s) begin
      smp_addr_r  <= ports_addr;
      smp_data_r  <= ports_wrdata;
      smp_wrena_r <= ports_wrena;
    end else begin
      smp_addr_r  <= smp_addr_r;
      smp_data_r  <= smp_data_r;
      smp_wrena_r <= smp_wrena_r;
    end
  end

  // A rising synchronised edge implies at least one low cycle, hence a
  // valid sample, so each strobe low period yields at most one commit
  assign commit_s  = strobe_s & ~strobe_d_r & smp_wrena_r;
  assign wr_ctrl_s = commit_s & (smp_addr_r == REG_CTRL);
  assign wr_mask_s = commit_s & (smp_addr_r == REG_MASK);
  assign wr_stat_s = commit_s & (smp_addr_r == REG_STAT);

  assign w5_start_s = wr_ctrl_s & smp_data_r[CTRL_W5RST];
  assign sl_start_s = wr_ctrl_s & smp_data_r[CTRL_SLRST];
  assign stat_w1c_s = {2{wr_stat_s}} & smp_data_r[1:0];

  // Data bit 6 has no storage anywhere in the map
  assign unused_s = smp_data_r[6];

  // CTRL and MASK storage
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= 5'b0_0000;
      mask_r <= 2'b00;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_r.rommap_win  <= smp_data_r[CTRL_WIN_MSB:CTRL_WIN_LSB];
        ctrl_r.rommap_ena  <= smp_data_r[CTRL_ROMENA];
        ctrl_r.w5300_ports <= smp_data_r[CTRL_W5PORTS];
        ctrl_r.int_ena     <= smp_data_r[CTRL_INTENA];
      end else begin
        ctrl_r <= ctrl_r;
      end
      if (wr_mask_s) begin
        mask_r <= smp_data_r[1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Interrupt synchronisers; each resets to its inactive level
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      w5_sync_r <= {SYNC_LEN{1'b1}};
      sl_sync_r <= {SYNC_LEN{1'b0}};
    end else begin
      w5_sync_r <= {w5_sync_r[SYNC_LEN-2:0], w5300_int_n};
      sl_sync_r <= {sl_sync_r[SYNC_LEN-2:0], sl811_intrq};
    end
  end

  assign w5_lvl_s = w5_sync_r[SYNC_LEN-1];
  assign sl_lvl_s = sl_sync_r[SYNC_LEN-1];

  // STAT next state: level-sticky set, W1C, cleared while the chip is reset
  always_comb begin
    stat_nxt_s          = stat_r;
    stat_nxt_s[STAT_W5] = stat_bit_next(stat_r[STAT_W5], w5_busy_s, ~w5_lvl_s,
                                        stat_w1c_s[STAT_W5]);
    stat_nxt_s[STAT_SL] = stat_bit_next(stat_r[STAT_SL], sl_busy_s, sl_lvl_s,
                                        stat_w1c_s[STAT_SL]);
  end

  // STAT register and the interrupt request, which follows STAT by a cycle
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_r  <= 2'b00;
      int_n_r <= 1'b1;
    end else begin
      stat_r  <= stat_nxt_s;
      int_n_r <= ~(ctrl_r.int_ena & (|(stat_r & mask_r)));
    end
  end

  zports_rstgen #(.RST_CYCLES(RST_CYCLES)) u_w5300_rst (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .start      (w5_start_s),
    .chip_rst_n (w5300_rst_n),
    .busy       (w5_busy_s)
  );

  zports_rstgen #(.RST_CYCLES(RST_CYCLES)) u_sl811_rst (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .start      (sl_start_s),
    .chip_rst_n (sl811_rst_n),
    .busy       (sl_busy_s)
  );

  // Read mux; reads have no side effects
  always_comb begin
    ports_rddata = 8'hFF;
    case (ports_addr)
      REG_CTRL: ports_rddata = {ctrl_r.int_ena, 1'b0, w5_busy_s, sl_busy_s,
                                ctrl_r.w5300_ports, ctrl_r.rommap_ena,
                                ctrl_r.rommap_win};
      REG_MASK: ports_rddata = {6'b00_0000, mask_r};
      REG_STAT: ports_rddata = {2'b00, sl_lvl_s, w5_lvl_s, 2'b00, stat_r};
      default:  ports_rddata = 8'hFF;
    endcase
  end

  assign rommap_win  = ctrl_r.rommap_win;
  assign rommap_ena  = ctrl_r.rommap_ena;
  assign w5300_ports = ctrl_r.w5300_ports;
  assign int_n       = int_n_r;

endmodule

// File: tb/tb_zports.sv
// tb_zports: directed stimulus with a scoreboard. Stimulus pushes expected
// observations into a queue; a monitor pops and compares them on the
// falling clock edge.
module tb_zports;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ports_wrena = 1'b0;
  logic       ports_wrstb_n = 1'b1;
  logic [1:0] ports_addr = 2'd0;
  logic [7:0] ports_wrdata = 8'h00;
  logic [7:0] ports_rddata;
  logic [1:0] rommap_win;
  logic       rommap_ena;
  logic       w5300_ports;
  logic       w5300_rst_n;
  logic       sl811_rst_n;
  logic       w5300_int_n = 1'b1;
  logic       sl811_intrq = 1'b0;
  logic       int_n;

  localparam int OBS_RD    = 0;
  localparam int OBS_WIN   = 1;
  localparam int OBS_ENA   = 2;
  localparam int OBS_PORTS = 3;
  localparam int OBS_W5RST = 4;
  localparam int OBS_SLRST = 5;
  localparam int OBS_INT   = 6;

  typedef struct {
    string      name;
    int         id;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 fclk = ~fclk;

  zports dut (
    .fclk          (fclk),
    .rst_n         (rst_n),
    .ports_wrena   (ports_wrena),
    .ports_wrstb_n (ports_wrstb_n),
    .ports_addr    (ports_addr),
    .ports_wrdata  (ports_wrdata),
    .ports_rddata  (ports_rddata),
    .rommap_win    (rommap_win),
    .rommap_ena    (rommap_ena),
    .w5300_ports   (w5300_ports),
    .w5300_rst_n   (w5300_rst_n),
    .sl811_rst_n   (sl811_rst_n),
    .w5300_int_n   (w5300_int_n),
    .sl811_intrq   (sl811_intrq),
    .int_n         (int_n)
  );

  function automatic logic [7:0] observe(input int id);
    logic [7:0] v;
    case (id)
      OBS_RD:    v = ports_rddata;
      OBS_WIN:   v = {6'd0, rommap_win};
      OBS_ENA:   v = {7'd0, rommap_ena};
      OBS_PORTS: v = {7'd0, w5300_ports};
      OBS_W5RST: v = {7'd0, w5300_rst_n};
      OBS_SLRST: v = {7'd0, sl811_rst_n};
      OBS_INT:   v = {7'd0, int_n};
      default:   v = 8'hEE;
    endcase
    return v;
  endfunction

  // Monitor: compare every queued expectation at the falling edge
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge fclk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = observe(e.id);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s actual=%h required=%h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge fclk);
      #1;
    end
  endtask

  task automatic expect_obs(input string name, input int id, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.id   = id;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic expect_rd(input string name, input logic [1:0] addr, input logic [7:0] exp);
    ports_addr = addr;
    expect_obs(name, OBS_RD, exp);
  endtask

  // Strobe low for `low` cycles, then return just after the commit edge
  task automatic wr(input logic [1:0] addr, input logic [7:0] data,
                    input logic ena, input int low);
    ports_addr    = addr;
    ports_wrdata  = data;
    ports_wrena   = ena;
    ports_wrstb_n = 1'b0;
    tick(low);
    ports_wrstb_n = 1'b1;
    tick(3);
    ports_wrena   = 1'b0;
  endtask

  initial begin
    // 1. reset values and chip reset hold after release
    tick(3);
    expect_rd("rst_addr0", 2'd0, 8'hFF);
    expect_obs("rst_int_n", OBS_INT, 8'h01);
    expect_obs("rst_romena", OBS_ENA, 8'h00);
    expect_obs("rst_ports", OBS_PORTS, 8'h00);
    tick(1);
    expect_rd("rst_mask", 2'd2, 8'h00);
    tick(1);
    expect_rd("rst_stat", 2'd3, 8'h10);
    rst_n = 1'b1;
    tick(1);
    expect_rd("hold_ctrl", 2'd1, 8'h30);
    expect_obs("hold_w5rst_first", OBS_W5RST, 8'h00);
    expect_obs("hold_slrst_first", OBS_SLRST, 8'h00);
    tick(198);
    expect_obs("hold_w5rst_last", OBS_W5RST, 8'h00);
    expect_obs("hold_slrst_last", OBS_SLRST, 8'h00);
    tick(1);
    expect_obs("hold_w5rst_end", OBS_W5RST, 8'h01);
    expect_obs("hold_slrst_end", OBS_SLRST, 8'h01);
    expect_rd("idle_ctrl", 2'd1, 8'h00);
    tick(2);

    // 2. CTRL write, then the same with wrena=0
    wr(2'd1, 8'h8E, 1'b1, 6);
    expect_obs("wr_win", OBS_WIN, 8'h02);
    expect_obs("wr_romena", OBS_ENA, 8'h01);
    expect_obs("wr_ports", OBS_PORTS, 8'h01);
    expect_rd("wr_ctrl", 2'd1, 8'h8E);
    tick(2);
    wr(2'd1, 8'h01, 1'b0, 6);
    expect_rd("nowr_ctrl", 2'd1, 8'h8E);
    expect_obs("nowr_win", OBS_WIN, 8'h02);
    tick(2);

    // 3. w5300 reset pulse, extended by a rewrite 100 cycles later
    wr(2'd1, 8'h20, 1'b1, 6);
    expect_obs("w5pulse_start", OBS_W5RST, 8'h00);
    expect_obs("w5pulse_sl", OBS_SLRST, 8'h01);
    expect_rd("w5pulse_busy", 2'd1, 8'h20);
    tick(91);
    wr(2'd1, 8'h20, 1'b1, 6);
    tick(100);
    expect_obs("w5pulse_extended", OBS_W5RST, 8'h00);
    tick(99);
    expect_obs("w5pulse_last", OBS_W5RST, 8'h00);
    expect_obs("w5pulse_sl_mid", OBS_SLRST, 8'h01);
    tick(1);
    expect_obs("w5pulse_end", OBS_W5RST, 8'h01);
    expect_rd("w5pulse_idle", 2'd1, 8'h00);
    tick(2);

    // 4. w5300 interrupt, sticky, W1C
    wr(2'd2, 8'h03, 1'b1, 6);
    expect_rd("mask_rd", 2'd2, 8'h03);
    tick(1);
    wr(2'd1, 8'h80, 1'b1, 6);
    w5300_int_n = 1'b0;
    tick(10);
    expect_rd("w5int_stat", 2'd3, 8'h01);
    expect_obs("w5int_int_n", OBS_INT, 8'h00);
    w5300_int_n = 1'b1;
    tick(5);
    expect_rd("w5int_sticky", 2'd3, 8'h11);
    expect_obs("w5int_sticky_int_n", OBS_INT, 8'h00);
    tick(1);
    wr(2'd3, 8'h01, 1'b1, 6);
    expect_rd("w1c_stat", 2'd3, 8'h10);
    expect_obs("w1c_int_n_lag", OBS_INT, 8'h00);
    tick(1);
    expect_obs("w1c_int_n", OBS_INT, 8'h01);
    tick(2);

    // 5. set wins over W1C, int_ena gate, STAT held 0 while chip in reset
    sl811_intrq = 1'b1;
    tick(5);
    expect_rd("slint_stat", 2'd3, 8'h32);
    expect_obs("slint_int_n", OBS_INT, 8'h00);
    tick(1);
    wr(2'd3, 8'h02, 1'b1, 6);
    expect_rd("setwins_stat", 2'd3, 8'h32);
    tick(1);
    wr(2'd1, 8'h00, 1'b1, 6);
    tick(1);
    expect_obs("intena0_int_n", OBS_INT, 8'h01);
    expect_rd("intena0_stat", 2'd3, 8'h32);
    tick(1);
    wr(2'd1, 8'h10, 1'b1, 6);
    tick(1);
    expect_rd("slbusy_stat", 2'd3, 8'h30);
    expect_obs("slbusy_rst", OBS_SLRST, 8'h00);
    expect_obs("slbusy_w5rst", OBS_W5RST, 8'h01);
    tick(2);
    sl811_intrq = 1'b0;

    // 6. async reset while strobe low; commit on the later rising edge
    ports_addr    = 2'd1;
    ports_wrdata  = 8'h04;
    ports_wrena   = 1'b1;
    ports_wrstb_n = 1'b0;
    tick(6);
    rst_n = 1'b0;
    tick(2);
    expect_obs("midrst_romena", OBS_ENA, 8'h00);
    expect_rd("midrst_ctrl", 2'd1, 8'h30);
    rst_n = 1'b1;
    tick(5);
    expect_obs("postrst_romena", OBS_ENA, 8'h00);
    ports_wrstb_n = 1'b1;
    tick(3);
    expect_obs("postrst_commit_romena", OBS_ENA, 8'h01);
    expect_rd("postrst_commit_ctrl", 2'd1, 8'h34);
    ports_wrena = 1'b0;
    tick(2);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
